// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates memory wait-states, taken branches
// and RAW/load-use hazards into freeze/flush controls, with performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             forward_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_ex_mem,
    output logic             bubble_wb,
    output logic             in_mem_wait,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic m1, m2, raw_mem, hazard;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_tmo(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    always_comb begin
        m1      = exe_wb_en & (exe_dest == id_src1);
        m2      = id_two_src & exe_wb_en & (exe_dest == id_src2);
        raw_mem = (mem_wb_en & (mem_dest == id_src1)) |
                  (id_two_src & mem_wb_en & (mem_dest == id_src2));
        if (forward_en)
            hazard = id_valid & exe_mem_r_en & (m1 | m2);
        else
            hazard = id_valid & (m1 | m2 | raw_mem);
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        mem_err_d     = mem_err_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        freeze_ex_mem = 1'b0;
        bubble_wb     = 1'b0;
        in_mem_wait   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_pc     = 1'b1;
                    freeze_if_id  = 1'b1;
                    freeze_ex_mem = 1'b1;
                    bubble_wb     = 1'b1;
                    state_d       = MEM_WAIT;
                    tmo_d         = 8'd1;
                end else if (branch_taken) begin
                    // The ID instruction is squashed, so its hazard no longer matters.
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    flush_cnt_d = sat_inc_cnt(flush_cnt_q);
                end else if (hazard) begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    flush_id_ex  = 1'b1;
                    stall_cnt_d  = sat_inc_cnt(stall_cnt_q);
                end
            end
            MEM_WAIT: begin
                in_mem_wait   = 1'b1;
                freeze_pc     = 1'b1;
                freeze_if_id  = 1'b1;
                freeze_ex_mem = 1'b1;
                bubble_wb     = 1'b1;
                wait_cnt_d    = sat_inc_cnt(wait_cnt_q);
                // A dropped request is treated as completion.
                if (mem_ready || !mem_req) begin
                    state_d = RUN;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = sat_inc_tmo(tmo_q);
                    if (tmo_q >= TMO_LIM)
                        mem_err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            freeze_pc     = 1'b0;
            freeze_if_id  = 1'b0;
            flush_if_id   = 1'b0;
            flush_id_ex   = 1'b0;
            freeze_ex_mem = 1'b0;
            bubble_wb     = 1'b0;
            in_mem_wait   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            tmo_q       <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: main instance (CNT_W=16, TIMEOUT=8) plus a
// 2-bit-counter instance sharing the same stimulus for the saturation case.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst, id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic forward_en, branch_taken, mem_req, mem_ready;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    logic freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_ex_mem, bubble_wb;
    logic in_mem_wait, mem_err;
    logic [15:0] stall_cnt, flush_cnt, wait_cnt;

    logic s_freeze_pc, s_freeze_if_id, s_flush_if_id, s_flush_id_ex, s_freeze_ex_mem;
    logic s_bubble_wb, s_in_mem_wait, s_mem_err;
    logic [1:0] s_stall_cnt, s_flush_cnt, s_wait_cnt;

    int errors = 0;
    int checks = 0;

    // {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_ex_mem, bubble_wb, in_mem_wait}
    logic [6:0] ctl;
    assign ctl = {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_ex_mem, bubble_wb, in_mem_wait};

    localparam logic [6:0] IDLE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1101000;
    localparam logic [6:0] FLUSH = 7'b0011000;
    localparam logic [6:0] MEMF  = 7'b1100110;
    localparam logic [6:0] WAIT  = 7'b1100111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze_ex_mem(freeze_ex_mem),
        .bubble_wb(bubble_wb), .in_mem_wait(in_mem_wait), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .TIMEOUT(8)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .freeze_ex_mem(s_freeze_ex_mem),
        .bubble_wb(s_bubble_wb), .in_mem_wait(s_in_mem_wait), .mem_err(s_mem_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt)
    );

    task automatic idle_inputs();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = 0;
        mem_wb_en = 0; mem_dest = 0; forward_en = 1;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic set_load_use();
        forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3;
        id_src1 = 4'd3; id_valid = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_load_use();
        rst = 1;
        #1;
        checks++; if (ctl !== IDLE) begin errors++; $display("FAIL reset_ctl_forced got=%b exp=%b", ctl, IDLE); end
        tick();
        rst = 0;
        idle_inputs();
        #1;
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || wait_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, wait_cnt); end
        checks++; if (mem_err !== 1'b0 || ctl !== IDLE) begin
            errors++; $display("FAIL reset_state got mem_err=%b ctl=%b exp 0/%b", mem_err, ctl, IDLE); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #1;
        checks++; if (ctl !== STALL) begin errors++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, STALL); end
        tick();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
        exe_mem_r_en = 0;
        #1;
        checks++; if (ctl !== IDLE) begin errors++; $display("FAIL fwd_no_load_ctl got=%b exp=%b", ctl, IDLE); end
        tick();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL fwd_no_load_cnt got=%0d exp=1", stall_cnt); end
        exe_mem_r_en = 1; id_valid = 0;
        #1;
        checks++; if (ctl !== IDLE) begin errors++; $display("FAIL invalid_id_ctl got=%b exp=%b", ctl, IDLE); end
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        forward_en = 0; mem_wb_en = 1; mem_dest = 4'd5; id_two_src = 1;
        id_src1 = 4'd1; id_src2 = 4'd5; id_valid = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctl !== STALL) begin errors++; $display("FAIL raw_ctl cyc=%0d got=%b exp=%b", i, ctl, STALL); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_cnt got=%0d exp=2", stall_cnt); end
        id_two_src = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctl !== IDLE) begin errors++; $display("FAIL raw_one_src_ctl cyc=%0d got=%b exp=%b", i, ctl, IDLE); end
            tick();
        end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_one_src_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        set_load_use();
        branch_taken = 1;
        #1;
        checks++; if (ctl !== FLUSH) begin errors++; $display("FAIL branch_ctl got=%b exp=%b", ctl, FLUSH); end
        tick();
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_cnts got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        #1;
        checks++; if (ctl !== MEMF) begin errors++; $display("FAIL mem_entry_ctl got=%b exp=%b", ctl, MEMF); end
        tick();
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            #1;
            checks++; if (ctl !== WAIT) begin errors++; $display("FAIL mem_wait_ctl cyc=%0d got=%b exp=%b", i, ctl, WAIT); end
            tick();
        end
        branch_taken = 0; mem_ready = 1;
        #1;
        checks++; if (ctl !== WAIT) begin errors++; $display("FAIL mem_ready_ctl got=%b exp=%b", ctl, WAIT); end
        tick();
        mem_req = 0; mem_ready = 0;
        #1;
        checks++; if (ctl !== IDLE) begin errors++; $display("FAIL mem_exit_ctl got=%b exp=%b", ctl, IDLE); end
        checks++; if (wait_cnt !== 16'd4 || flush_cnt !== 16'd0) begin
            errors++; $display("FAIL mem_cnts got wait=%0d flush=%0d exp 4/0", wait_cnt, flush_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (mem_err !== 1'b0 || in_mem_wait !== 1'b1) begin
            errors++; $display("FAIL timeout_early got err=%b wait=%b exp 0/1", mem_err, in_mem_wait); end
        tick();
        checks++; if (mem_err !== 1'b1 || in_mem_wait !== 1'b1) begin
            errors++; $display("FAIL timeout_set got err=%b wait=%b exp 1/1", mem_err, in_mem_wait); end
        mem_ready = 1;
        tick();
        mem_req = 0; mem_ready = 0;
        #1;
        checks++; if (mem_err !== 1'b1 || ctl !== IDLE) begin
            errors++; $display("FAIL timeout_sticky got err=%b ctl=%b exp 1/%b", mem_err, ctl, IDLE); end
        do_reset();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_rst_clear got=%b exp=0", mem_err); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        tick(); tick(); tick();
        rst = 1;
        #1;
        checks++; if (ctl !== IDLE) begin errors++; $display("FAIL rst_mid_wait_ctl got=%b exp=%b", ctl, IDLE); end
        tick();
        rst = 0; mem_req = 0;
        #1;
        checks++; if (ctl !== IDLE || wait_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_wait_after got ctl=%b wait=%0d exp %b/0", ctl, wait_cnt, IDLE); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        for (int i = 0; i < 5; i++) tick();
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_stall_cnt got=%0d exp=3", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL wide_stall_cnt got=%0d exp=5", stall_cnt); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_raw_nofwd();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the freeze and flush controls of the PC, the IF/ID register, the ID/EX register (its Flush input) and the EX/MEM register.
- Resolves three events, in priority order: memory wait-states, taken branches, and load-use/RAW data hazards.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the stall/flush/wait performance counters.
- TIMEOUT, 255, MEM_WAIT cycles after which mem_err is set (must fit in 8 bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  4  ID first source register (Rn).
- id_src2  in  4  ID second source register (Rm/Rd for store).
- id_two_src  in  1  id_src2 is actually read.
- exe_wb_en  in  1  EX-stage instruction writes a register.
- exe_mem_r_en  in  1  EX-stage instruction is a load.
- exe_dest  in  4  EX-stage destination register.
- mem_wb_en  in  1  MEM-stage instruction writes a register.
- mem_dest  in  4  MEM-stage destination register.
- forward_en  in  1  forwarding unit enabled.
- branch_taken  in  1  EX-stage branch resolved taken.
- mem_req  in  1  MEM stage accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  clear IF/ID register.
- flush_id_ex  out  1  load bubble into ID/EX register (drives its Flush).
- freeze_ex_mem  out  1  hold ID/EX and EX/MEM registers.
- bubble_wb  out  1  insert bubble into MEM/WB register.
- in_mem_wait  out  1  FSM is in MEM_WAIT.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  hazard stall cycles.
- flush_cnt  out  CNT_W  branch flush events.
- wait_cnt  out  CNT_W  memory wait cycles.

Behaviour:
- Reset:
  - When rst is high at a clock edge: state goes to RUN, all counters clear, mem_err clears, timeout counter clears.
  - While rst is high, all control outputs are forced to 0.
- Data hazard (combinational), gated by id_valid:
  - m1 = exe_wb_en & exe_dest==id_src1.
  - m2 = id_two_src & exe_wb_en & exe_dest==id_src2.
  - When forward_en=0: hazard = m1 | m2 | (mem_wb_en & mem_dest==id_src1) | (id_two_src & mem_wb_en & mem_dest==id_src2).
  - When forward_en=1: hazard = exe_mem_r_en & (m1|m2).
- FSM has 2 states, RUN and MEM_WAIT. State is registered; outputs are combinational from state and inputs.
- RUN priority 1, mem_req & ~mem_ready:
  - Assert freeze_pc, freeze_if_id, freeze_ex_mem and bubble_wb.
  - Next state is MEM_WAIT; the timeout counter loads 1.
  - branch_taken and hazard are ignored this cycle.
- RUN priority 2, branch_taken:
  - Assert flush_if_id and flush_id_ex for exactly this cycle.
  - flush_cnt increments.
  - Any hazard is ignored, because the ID instruction is squashed.
- RUN priority 3, hazard:
  - Assert freeze_pc, freeze_if_id and flush_id_ex.
  - stall_cnt increments.
  - Repeats every cycle the hazard persists.
- RUN, none of the above: all control outputs are 0.
- MEM_WAIT:
  - in_mem_wait=1; freeze_pc, freeze_if_id, freeze_ex_mem and bubble_wb stay asserted every cycle, including the mem_ready cycle.
  - wait_cnt increments every MEM_WAIT cycle.
  - mem_ready=1 returns the FSM to RUN next cycle; the timeout counter clears.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT, mem_err sets (sticky until rst) and the FSM stays in MEM_WAIT.
  - branch_taken and hazard are ignored; the frozen stages re-present them after exit.
  - mem_req dropping while in MEM_WAIT is treated as mem_ready, so the FSM returns to RUN.
- Counters saturate at all-ones and never wrap.
- The timeout counter is 8 bits and saturates.
- rst mid-MEM_WAIT returns to RUN with outputs 0 in the same cycle.

Test Plan:
1. Load-use: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_valid=1 for 1 cycle -> freeze_pc=freeze_if_id=flush_id_ex=1 that cycle; stall_cnt 0->1. Same with exe_mem_r_en=0 -> no stall.
2. No-forward RAW: forward_en=0, mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 for 2 cycles -> 2 stall cycles; stall_cnt=2. Same with id_two_src=0 -> 0 stalls.
3. Branch over hazard: branch_taken=1 together with an active hazard -> flush_if_id=flush_id_ex=1, freeze_pc=0; flush_cnt=1, stall_cnt unchanged.
4. Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> freeze_ex_mem=1 for 5 cycles; in_mem_wait high 4 cycles; wait_cnt=4; RUN on cycle 6. A branch_taken pulse during the wait produces no flush.
5. Timeout: TIMEOUT=8, mem_ready held 0 -> mem_err=1 after the 8th MEM_WAIT cycle and stays 1 after mem_ready; only rst clears it.
6. Reset mid-wait: rst=1 during MEM_WAIT -> all outputs 0 that cycle; counters=0 and state RUN after the edge. Saturation: preset CNT_W=2, force 5 hazard cycles -> stall_cnt=3.
